// File: rtl/fe_pc_redirect.sv
// Fetch-stage program counter with branch redirect, squash and shadow window.
// The PC advances sequentially, holds on decode stalls and jumps to resolved
// branch targets from execute. After a redirect, resolutions arriving in the
// next SQUASH_CYCLES cycles come from squashed wrong-path slots and are ignored.
module fe_pc_redirect #(
    parameter int               DBITS         = 32,
    parameter logic [DBITS-1:0] RESET_PC      = '0,
    parameter int               INSTBYTES     = 4,
    parameter int               SQUASH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_cond_i,
    input  logic [DBITS-1:0] br_target_i,
    input  logic             stall_i,
    output logic [DBITS-1:0] pc_o,
    output logic [DBITS-1:0] pcplus_o,
    output logic             valid_o,
    output logic [DBITS-1:0] inst_count_o,
    output logic             squash_o,
    output logic             misalign_o,
    output logic [15:0]      redirect_count_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SHADOW = 2'd2
    } state_t;

    localparam logic [DBITS-1:0] PC_INC     = DBITS'(INSTBYTES);
    localparam logic [1:0]       SHADOW_LEN = 2'(SQUASH_CYCLES);

    state_t           state_q, state_d;
    logic [1:0]       shcnt_q, shcnt_d;
    logic [DBITS-1:0] pc_q, pc_d;
    logic [DBITS-1:0] icnt_q, icnt_d;
    logic [15:0]      rcnt_q, rcnt_d;
    logic             mis_q, mis_d;
    logic             acc;
    logic             fetch_adv;

    // State register: controller state and remaining shadow cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            shcnt_q <= 2'd0;
        end else begin
            state_q <= state_d;
            shcnt_q <= shcnt_d;
        end
    end

    // Next state: BOOT lasts one cycle; an accepted redirect opens the shadow window,
    // which counts down every cycle (stalled or not) and closes after its last cycle.
    always_comb begin
        state_d = state_q;
        shcnt_d = shcnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (acc && (SQUASH_CYCLES != 0)) begin
                    state_d = SHADOW;
                    shcnt_d = SHADOW_LEN;
                end
            end
            SHADOW: begin
                shcnt_d = shcnt_q - 2'd1;
                if (shcnt_q <= 2'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                shcnt_d = 2'd0;
            end
        endcase
    end

    // Outputs of the controller: only RUN may accept a redirect, which also squashes.
    always_comb begin
        valid_o   = (state_q != BOOT);
        acc       = br_cond_i & (state_q == RUN);
        squash_o  = acc;
        fetch_adv = valid_o & ~stall_i & ~acc;
    end

    // Datapath next values: redirect wins over stall; otherwise advance unless stalled.
    always_comb begin
        pc_d   = pc_q;
        icnt_d = icnt_q;
        rcnt_d = rcnt_q;
        mis_d  = mis_q;
        if (acc) begin
            pc_d = {br_target_i[DBITS-1:2], 2'b00};
            if (br_target_i[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
            if (rcnt_q != 16'hFFFF) begin
                rcnt_d = rcnt_q + 16'd1;
            end
        end else if (fetch_adv) begin
            pc_d   = pc_q + PC_INC;
            icnt_d = icnt_q + 1'b1;
        end
    end

    // Datapath registers: PC, fetch count, redirect count and sticky misalign flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            icnt_q <= '0;
            rcnt_q <= 16'd0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            icnt_q <= icnt_d;
            rcnt_q <= rcnt_d;
            mis_q  <= mis_d;
        end
    end

    assign pc_o             = pc_q;
    assign pcplus_o         = pc_q + PC_INC;
    assign inst_count_o     = icnt_q;
    assign redirect_count_o = rcnt_q;
    assign misalign_o       = mis_q;

endmodule

// File: tb/tb_fe_pc_redirect.sv
// Testbench for fe_pc_redirect: table of per-cycle vectors fed through a
// scoreboard queue, plus a redirect-saturation run on a zero-shadow instance.
module tb_fe_pc_redirect;

    typedef struct {
        logic        rst_n;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic [31:0] pc;
        logic        valid;
        logic        squash;
        logic [31:0] icnt;
        logic [15:0] rcnt;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_cond;
    logic [31:0] br_target;
    logic        stall;
    logic [31:0] pc, pcplus, inst_count;
    logic        valid, squash, misalign;
    logic [15:0] redirect_count;

    logic        sat_br;
    logic [31:0] sat_target;
    logic        sat_stall;
    logic [31:0] sat_pc, sat_pcplus, sat_inst_count;
    logic        sat_valid, sat_squash, sat_misalign;
    logic [15:0] sat_redirect_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t sb_q[$];

    fe_pc_redirect dut (
        .clk              (clk),
        .reset            (reset),
        .br_cond_i        (br_cond),
        .br_target_i      (br_target),
        .stall_i          (stall),
        .pc_o             (pc),
        .pcplus_o         (pcplus),
        .valid_o          (valid),
        .inst_count_o     (inst_count),
        .squash_o         (squash),
        .misalign_o       (misalign),
        .redirect_count_o (redirect_count)
    );

    // Zero-length shadow lets a redirect be accepted every cycle for the saturation run.
    fe_pc_redirect #(.SQUASH_CYCLES(0)) dut_sat (
        .clk              (clk),
        .reset            (reset),
        .br_cond_i        (sat_br),
        .br_target_i      (sat_target),
        .stall_i          (sat_stall),
        .pc_o             (sat_pc),
        .pcplus_o         (sat_pcplus),
        .valid_o          (sat_valid),
        .inst_count_o     (sat_inst_count),
        .squash_o         (sat_squash),
        .misalign_o       (sat_misalign),
        .redirect_count_o (sat_redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst_n, input logic br, input logic [31:0] tgt,
                           input logic stl, input logic [31:0] epc, input logic evalid,
                           input logic esq, input logic [31:0] eicnt,
                           input logic [15:0] ercnt, input logic emis);
        vec_t v;
        v.rst_n = rst_n; v.br = br; v.tgt = tgt; v.stall = stl;
        v.pc = epc; v.valid = evalid; v.squash = esq;
        v.icnt = eicnt; v.rcnt = ercnt; v.mis = emis;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        reset     = v.rst_n;
        br_cond   = v.br;
        br_target = v.tgt;
        stall     = v.stall;
        sb_q.push_back(v);
    endtask

    task automatic check_output(input int idx);
        vec_t        e;
        logic [31:0] exp_plus;
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL row%0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
            e = sb_q.pop_front();
            exp_plus = e.pc + 32'd4;
            check_val($sformatf("row%0d pc", idx),     pc,                     e.pc);
            check_val($sformatf("row%0d pcplus", idx), pcplus,                 exp_plus);
            check_val($sformatf("row%0d valid", idx),  {31'd0, valid},         {31'd0, e.valid});
            check_val($sformatf("row%0d squash", idx), {31'd0, squash},        {31'd0, e.squash});
            check_val($sformatf("row%0d icnt", idx),   inst_count,             e.icnt);
            check_val($sformatf("row%0d rcnt", idx),   {16'd0, redirect_count}, {16'd0, e.rcnt});
            check_val($sformatf("row%0d mis", idx),    {31'd0, misalign},      {31'd0, e.mis});
        end
    endtask

    initial begin
        reset      = 1'b0;
        br_cond    = 1'b0;
        br_target  = 32'd0;
        stall      = 1'b0;
        sat_br     = 1'b0;
        sat_target = 32'd0;
        sat_stall  = 1'b0;

        //       rst br tgt           stl | pc           v  sq icnt rcnt mis
        add_vec(1, 0, 32'h0,        0,   32'h0,        0, 0, 0,  0, 0); // BOOT
        add_vec(1, 0, 32'h0,        0,   32'h0,        1, 0, 0,  0, 0);
        add_vec(1, 0, 32'h0,        0,   32'h4,        1, 0, 1,  0, 0);
        add_vec(1, 0, 32'h0,        1,   32'h8,        1, 0, 2,  0, 0); // stall x3
        add_vec(1, 0, 32'h0,        1,   32'h8,        1, 0, 2,  0, 0);
        add_vec(1, 0, 32'h0,        1,   32'h8,        1, 0, 2,  0, 0);
        add_vec(1, 0, 32'h0,        0,   32'h8,        1, 0, 2,  0, 0);
        add_vec(1, 0, 32'h0,        0,   32'hC,        1, 0, 3,  0, 0);
        add_vec(1, 1, 32'h100,      0,   32'h10,       1, 1, 4,  0, 0); // redirect
        add_vec(1, 1, 32'h200,      0,   32'h100,      1, 0, 4,  1, 0); // shadow 1
        add_vec(1, 1, 32'h200,      0,   32'h104,      1, 0, 5,  1, 0); // shadow 2
        add_vec(1, 1, 32'h300,      0,   32'h108,      1, 1, 6,  1, 0); // honoured
        add_vec(1, 0, 32'h0,        0,   32'h300,      1, 0, 6,  2, 0);
        add_vec(1, 0, 32'h0,        0,   32'h304,      1, 0, 7,  2, 0);
        add_vec(1, 1, 32'h122,      1,   32'h308,      1, 1, 8,  2, 0); // stall+misaligned
        add_vec(1, 0, 32'h0,        1,   32'h120,      1, 0, 8,  3, 1);
        add_vec(1, 0, 32'h0,        0,   32'h120,      1, 0, 8,  3, 1);
        add_vec(1, 0, 32'h0,        0,   32'h124,      1, 0, 9,  3, 1);
        add_vec(1, 1, 32'h40,       0,   32'h128,      1, 1, 10, 3, 1);
        add_vec(1, 1, 32'h500,      0,   32'h40,       1, 0, 10, 4, 1); // shadow 1
        add_vec(0, 1, 32'h600,      0,   32'h0,        0, 0, 0,  0, 0); // reset mid-shadow
        add_vec(1, 1, 32'h600,      0,   32'h0,        0, 0, 0,  0, 0); // BOOT ignores br
        add_vec(1, 0, 32'h0,        0,   32'h0,        1, 0, 0,  0, 0);
        add_vec(1, 1, 32'hFFFFFFFC, 0,   32'h4,        1, 1, 1,  0, 0);
        add_vec(1, 0, 32'h0,        0,   32'hFFFFFFFC, 1, 0, 1,  1, 0); // wrap
        add_vec(1, 0, 32'h0,        0,   32'h0,        1, 0, 2,  1, 0);
        add_vec(1, 0, 32'h0,        0,   32'h4,        1, 0, 3,  1, 0);

        repeat (2) @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(i);
        end
        br_cond = 1'b0;
        stall   = 1'b0;

        // Saturation: one accepted redirect per cycle on the zero-shadow instance.
        @(negedge clk);
        sat_br     = 1'b1;
        sat_target = 32'h7;
        #1;
        check_val("sat start rcnt", {16'd0, sat_redirect_count}, 32'd0);
        check_val("sat squash", {31'd0, sat_squash}, 32'd1);
        repeat (65534) @(negedge clk);
        #1;
        check_val("sat rcnt FFFE", {16'd0, sat_redirect_count}, 32'h0000FFFE);
        @(negedge clk);
        #1;
        check_val("sat rcnt FFFF", {16'd0, sat_redirect_count}, 32'h0000FFFF);
        repeat (4) @(negedge clk);
        #1;
        check_val("sat rcnt hold", {16'd0, sat_redirect_count}, 32'h0000FFFF);
        check_val("sat pc", sat_pc, 32'h4);
        check_val("sat mis", {31'd0, sat_misalign}, 32'd1);
        check_val("main mis cleared", {31'd0, misalign}, 32'd0);
        sat_br = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_pc_redirect.md
# fe_pc_redirect

Fetch-side program-counter controller: the receiving end of the execute stage's branch-resolution channel (`{br_cond, newpc}`). It holds the architectural fetch PC and advances it sequentially. It stalls on decode hazards and redirects to a resolved branch/jump target. It squashes wrong-path fetch/decode slots and ignores stale resolutions while the squashed bubbles drain. It sits in the FE stage and drives the instruction-memory address and the FE latch's PC, pcplus and instruction-count fields.

## Interface
- `DBITS`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `INSTBYTES`, 4, sequential PC increment
- `SQUASH_CYCLES`, 2, shadow-window length after a redirect (FE and DE wrong-path slots)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `br_cond_i`  in  1  execute stage: branch taken / jump resolved this cycle
- `br_target_i`  in  DBITS  execute stage: resolved target PC
- `stall_i`  in  1  decode hazard stall: hold fetch
- `pc_o`  out  DBITS  current fetch PC (registered)
- `pcplus_o`  out  DBITS  `pc_o + INSTBYTES` (combinational from `pc_o`)
- `valid_o`  out  1  fetch slot carries a real instruction
- `inst_count_o`  out  DBITS  count of accepted fetches (registered)
- `squash_o`  out  1  clear FE and DE latches this cycle
- `misalign_o`  out  1  sticky: a redirect target had `[1:0] != 0`
- `redirect_count_o`  out  16  accepted redirects, saturating at 16'hFFFF

## Operation
- States: BOOT, RUN, SHADOW; 2-bit shadow counter `shcnt`.
- BOOT: entered on reset. `valid_o=0`, PC held, no count increments. Moves to RUN unconditionally on the next edge.
- Redirect accepted: `acc = br_cond_i & (state != SHADOW) & (state != BOOT)`.
- `squash_o = acc` (combinational, same cycle as `br_cond_i`).
- On `acc`:
  - Next `pc_o = {br_target_i[DBITS-1:2], 2'b00}`.
  - If `br_target_i[1:0] != 0`, set `misalign_o` (cleared only by reset).
  - `redirect_count_o` +1 unless already saturated.
  - Go to SHADOW with `shcnt = SQUASH_CYCLES`.
- Redirect has priority over `stall_i`. A redirect during a stall still loads the target and asserts `squash_o`.
- RUN, no `acc`:
  - `stall_i=0`: `pc_o <= pc_o + INSTBYTES`, `inst_count_o` +1.
  - `stall_i=1`: PC and count held.
- SHADOW:
  - `valid_o=1`; fetch proceeds from the target with the same stall rules as RUN.
  - `br_cond_i` is ignored: no squash, no redirect, counters unaffected.
  - `shcnt` decrements every cycle, including stalled cycles. At `shcnt==1` the next state is RUN.
- `inst_count_o` increments only when `valid_o & ~stall_i & ~squash_o`. It wraps modulo 2^DBITS.
- Adds are modulo 2^DBITS. PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- `valid_o = (state != BOOT)`.

## Timing
- Reset (async, `reset=0`):
  - `pc_o=RESET_PC`, `inst_count_o=0`, `redirect_count_o=0`.
  - `misalign_o=0`, state BOOT, `shcnt=0`.
  - `valid_o=0`, `squash_o=0` (`squash_o` is forced low in BOOT regardless of `br_cond_i`).
- Reset asserted mid-SHADOW or mid-stall: immediate return to reset values. No pending redirect survives.
- Redirect latency: `br_cond_i` high in cycle N → `squash_o` high in N → `pc_o = target` from N+1.
- Shadow: `br_cond_i` is ignored in cycles N+1 … N+SQUASH_CYCLES and honoured again from N+SQUASH_CYCLES+1.
- Stall: PC frozen in the same cycle `stall_i` is high; it advances on the first edge after `stall_i` falls.
- `pcplus_o` tracks `pc_o` with zero added latency.

## Test plan
- Reset/boot:
  - Stimulus: release `reset`; `stall_i=0` and `br_cond_i=0` in every cycle.
  - Response: `valid_o=0`, `pc_o=0` in the first cycle. Then `pc_o` = 0, 4, 8, 12 on successive cycles with `valid_o=1`. `inst_count_o` = 1, 2, 3 trailing.
- Stall:
  - Stimulus: with `pc_o=8`, hold `stall_i=1` for 3 cycles.
  - Response: `pc_o=8` and `inst_count_o` constant for 3 cycles, then `pc_o=12`.
- Redirect:
  - Stimulus: at `pc_o=16`, pulse `br_cond_i=1`, `br_target_i=32'h100`.
  - Response: `squash_o=1` in the same cycle, `pc_o=32'h100` next cycle, `redirect_count_o=1`, `inst_count_o` not incremented in the squash cycle.
- Shadow:
  - Stimulus: redirect to 0x100; in each of the next 2 cycles assert `br_cond_i` with target 0x200; in the 3rd cycle assert `br_cond_i` with target 0x300.
  - Response: shadow cycles give no squash and `pc_o` 0x100 → 0x104 → 0x108. The 3rd-cycle resolution is honoured: `pc_o=0x300`, `redirect_count_o=2`.
- Redirect during stall with misaligned target:
  - Stimulus: `stall_i=1` together with `br_cond_i=1`, target 32'h0000_0122.
  - Response: `squash_o=1`, next `pc_o=32'h120`, `misalign_o=1`, and `misalign_o` stays 1 until reset.
- Reset mid-shadow and saturation:
  - Stimulus: assert `reset=0` in shadow cycle 1, then release.
  - Response: BOOT again, `pc_o=RESET_PC`, all counts 0.
  - Stimulus: force 65536 accepted redirects.
  - Response: `redirect_count_o` holds at 16'hFFFF.
